// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM for a multicycle RV32-style datapath
//               (lw, sw, R-type, beq and an optional I-type ALU path).
//               It has one Moore state machine. PCWrite and IRWrite also
//               look at zero and mem_ready. ImmSrc is decoded from op.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MULTICYCLE_CONTROLLER_ITYPE_EN - when defined, op=0010011 is executed
//   through EXECUTEI. When undefined, op=0010011 is flagged as illegal in
//   DECODE.
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset (state -> FETCH)
//   op[6:0]    in   opcode field of the instruction register
//   zero       in   ALU zero flag (branch decision)
//   mem_ready  in   memory access completes this cycle
//   PCWrite    out  PC load enable
//   AdrSrc     out  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register / OldPC load enable
//   RegWrite   out  register file write enable
//   ResultSrc  out  result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA    out  ALU A mux (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    out  ALU B mux (00 rs2, 01 ImmExt, 10 constant 4)
//   ALUOp      out  ALU op class (00 add, 01 sub, 10 funct-decoded)
//   ImmSrc     out  immediate format select
//   illegal_op out  one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0] out  current state encoding (debug)
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        BEQ      = 4'd9
    } state_t;

    // Opcodes
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;

    // Mux / ALU encodings
    localparam logic [1:0] c_RES_ALUOUT  = 2'b00;
    localparam logic [1:0] c_RES_DATA    = 2'b01;
    localparam logic [1:0] c_RES_ALURES  = 2'b10;
    localparam logic [1:0] c_SRCA_PC     = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] c_SRCA_RS1    = 2'b10;
    localparam logic [1:0] c_SRCB_RS2    = 2'b00;
    localparam logic [1:0] c_SRCB_IMM    = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b10;
    localparam logic [1:0] c_ALU_ADD     = 2'b00;
    localparam logic [1:0] c_ALU_SUB     = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT   = 2'b10;
    localparam logic [1:0] c_IMM_I       = 2'b00;
    localparam logic [1:0] c_IMM_S       = 2'b01;
    localparam logic [1:0] c_IMM_B       = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_immsrc;
    logic       w_op_supported;

    // ------------------------------------------------------------------
    // Opcode classification and immediate format
    // ------------------------------------------------------------------
    always_comb begin
        w_op_supported = 1'b0;
        case (op)
            c_OP_LOAD,
            c_OP_STORE,
            c_OP_RTYPE,
            c_OP_BRANCH: w_op_supported = 1'b1;
`ifdef MULTICYCLE_CONTROLLER_ITYPE_EN
            c_OP_ITYPE:  w_op_supported = 1'b1;
`endif
            default:     w_op_supported = 1'b0;
        endcase
    end

    always_comb begin
        w_immsrc = c_IMM_I;
        case (op)
            c_OP_LOAD:   w_immsrc = c_IMM_I;
            c_OP_STORE:  w_immsrc = c_IMM_S;
            c_OP_BRANCH: w_immsrc = c_IMM_B;
            c_OP_ITYPE:  w_immsrc = c_IMM_I;
            default:     w_immsrc = c_IMM_I;
        endcase
    end

    // ------------------------------------------------------------------
    // State register. The asynchronous reset abandons any instruction in
    // flight, so a pending MemWrite/RegWrite disappears immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:    w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    c_OP_LOAD,
                    c_OP_STORE:  w_next = MEMADR;
                    c_OP_RTYPE:  w_next = EXECUTER;
                    c_OP_BRANCH: w_next = BEQ;
`ifdef MULTICYCLE_CONTROLLER_ITYPE_EN
                    c_OP_ITYPE:  w_next = EXECUTEI;
`endif
                    default:     w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = (op == c_OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    w_next = FETCH;
            MEMWRITE: w_next = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: w_next = ALUWB;
            ALUWB:    w_next = FETCH;
`ifdef MULTICYCLE_CONTROLLER_ITYPE_EN
            EXECUTEI: w_next = ALUWB;
`endif
            BEQ:      w_next = FETCH;
            // Unused encodings (and EXECUTEI when I-type is disabled)
            // go back to FETCH.
            default:  w_next = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = c_RES_ALUOUT;
        ALUSrcA    = c_SRCA_PC;
        ALUSrcB    = c_SRCB_RS2;
        ALUOp      = c_ALU_ADD;
        ImmSrc     = w_immsrc;
        illegal_op = 1'b0;
        case (r_state)
            FETCH: begin
                // During reset the state already reads FETCH. The two load
                // enables are gated so that nothing is captured until the
                // first edge after reset is released.
                PCWrite   = mem_ready & ~rst;
                IRWrite   = mem_ready & ~rst;
                AdrSrc    = 1'b0;
                ALUSrcA   = c_SRCA_PC;
                ALUSrcB   = c_SRCB_FOUR;
                ALUOp     = c_ALU_ADD;
                ResultSrc = c_RES_ALURES;
            end
            DECODE: begin
                ALUSrcA    = c_SRCA_OLDPC;
                ALUSrcB    = c_SRCB_IMM;
                ALUOp      = c_ALU_ADD;
                illegal_op = ~w_op_supported;
            end
            MEMADR: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
                ALUOp   = c_ALU_ADD;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = c_RES_ALUOUT;
            end
            MEMWB: begin
                ResultSrc = c_RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                // Held high for the whole access, including stall cycles.
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_RS2;
                ALUOp   = c_ALU_FUNCT;
            end
            ALUWB: begin
                ResultSrc = c_RES_ALUOUT;
                RegWrite  = 1'b1;
            end
`ifdef MULTICYCLE_CONTROLLER_ITYPE_EN
            EXECUTEI: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
                ALUOp   = c_ALU_FUNCT;
            end
`endif
            BEQ: begin
                ALUSrcA   = c_SRCA_RS1;
                ALUSrcB   = c_SRCB_RS2;
                ALUOp     = c_ALU_SUB;
                ResultSrc = c_RES_ALUOUT;
                PCWrite   = zero;
            end
            default: begin
                // Unused encodings drive every control output to 0.
                ImmSrc = 2'b00;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. An instruction
//               level model expands each opcode into its expected state walk
//               and the control word for every cycle. A monitor compares
//               these against the DUT on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .illegal_op (illegal_op),
        .state      (state)
    );

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rsrc, asrc, bsrc, aluop, imm;
        logic       ill;
        logic [3:0] st;
    } ctrl_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] e;
    } dchk_t;

    localparam logic [6:0] c_LW   = 7'b0000011;
    localparam logic [6:0] c_SW   = 7'b0100011;
    localparam logic [6:0] c_RT   = 7'b0110011;
    localparam logic [6:0] c_BEQ  = 7'b1100011;
    localparam logic [6:0] c_IT   = 7'b0010011;

    ctrl_t act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, state};

    ctrl_t exp_q[$];
    dchk_t dq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    ctrl_t mon_e;
    dchk_t mon_d;
    int    mon_cyc = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit op_legal(input logic [6:0] o);
        if (o == c_LW || o == c_SW || o == c_RT || o == c_BEQ) return 1'b1;
`ifdef MULTICYCLE_CONTROLLER_ITYPE_EN
        if (o == c_IT) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == c_SW)  return 2'b01;
        if (o == c_BEQ) return 2'b10;
        return 2'b00;
    endfunction

    // Control word the listed state must show for the given inputs.
    function automatic ctrl_t model(input int st, input logic [6:0] o,
                                    input logic mr, input logic z);
        ctrl_t c;
        c     = '0;
        c.st  = 4'(st);
        c.imm = imm_of(o);
        case (st)
            0: begin c.pcw = mr; c.irw = mr; c.rsrc = 2'b10; c.bsrc = 2'b10; end
            1: begin c.asrc = 2'b01; c.bsrc = 2'b01; c.ill = ~op_legal(o); end
            2: begin c.asrc = 2'b10; c.bsrc = 2'b01; end
            3: begin c.adr = 1'b1; end
            4: begin c.rsrc = 2'b01; c.rw = 1'b1; end
            5: begin c.adr = 1'b1; c.mw = 1'b1; end
            6: begin c.asrc = 2'b10; c.aluop = 2'b10; end
            7: begin c.rw = 1'b1; end
            8: begin c.asrc = 2'b10; c.bsrc = 2'b01; c.aluop = 2'b10; end
            9: begin c.asrc = 2'b10; c.aluop = 2'b01; c.pcw = z; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic pick_z(input int zsel);
        if (zsel == 0) return 1'b0;
        if (zsel == 1) return 1'b1;
        return rbit();
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic dchk(input string name, input logic [31:0] a, input logic [31:0] e);
        dq.push_back('{name, a, e});
    endtask

    task automatic cycle(input int st, input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(model(st, op, mr, z));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int st, input int stalls, input int zsel);
        for (int i = 0; i < stalls; i++) cycle(st, 1'b0, pick_z(zsel));
        cycle(st, 1'b1, pick_z(zsel));
    endtask

    // One instruction: FETCH, DECODE, then the opcode's execution steps.
    task automatic do_instr(input logic [6:0] o, input int sf, input int sm, input int zsel);
        op = o;
        wait_step(0, sf, zsel);
        cycle(1, rbit(), pick_z(zsel));
        if (o == c_LW) begin
            cycle(2, rbit(), pick_z(zsel));
            wait_step(3, sm, zsel);
            cycle(4, rbit(), pick_z(zsel));
        end else if (o == c_SW) begin
            cycle(2, rbit(), pick_z(zsel));
            wait_step(5, sm, zsel);
        end else if (o == c_RT) begin
            cycle(6, rbit(), pick_z(zsel));
            cycle(7, rbit(), pick_z(zsel));
        end else if (o == c_BEQ) begin
            cycle(9, rbit(), pick_z(zsel));
        end else if (op_legal(o)) begin
            cycle(8, rbit(), pick_z(zsel));
            cycle(7, rbit(), pick_z(zsel));
        end
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 5))
            0: o = c_LW;
            1: o = c_SW;
            2: o = c_RT;
            3: o = c_BEQ;
            4: o = c_IT;
            default: begin
                o = 7'($urandom);
                while (op_legal(o) || o == c_IT) o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    function automatic int rand_stall();
        return ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: sole owner of the comparison counters
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        mon_cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (act !== mon_e) begin
                n_err++;
                $display("FAIL ctrl_word cycle %0d: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b op=%b imm=%b ill=%b ; required st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b op=%b imm=%b ill=%b",
                         mon_cyc, act.st, act.pcw, act.adr, act.mw, act.irw, act.rw, act.rsrc,
                         act.asrc, act.bsrc, act.aluop, act.imm, act.ill,
                         mon_e.st, mon_e.pcw, mon_e.adr, mon_e.mw, mon_e.irw, mon_e.rw, mon_e.rsrc,
                         mon_e.asrc, mon_e.bsrc, mon_e.aluop, mon_e.imm, mon_e.ill);
            end
        end
        while (dq.size() > 0) begin
            mon_d = dq.pop_front();
            n_cmp++;
            if (mon_d.a !== mon_d.e) begin
                n_err++;
                $display("FAIL %s: got 0x%0h required 0x%0h", mon_d.name, mon_d.a, mon_d.e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset, checked while rst stays high and mem_ready=1.
        #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b1;
        op        = c_LW;
        @(posedge clk); #2;
        dchk("reset_vec_lw", 32'(act), 32'(model(0, op, 1'b0, zero)));
        op = c_SW;
        @(posedge clk); #2;
        dchk("reset_vec_sw", 32'(act), 32'(model(0, op, 1'b0, zero)));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed instruction walks
        do_instr(c_LW,  0, 0, 2);          // 0,1,2,3,4
        do_instr(c_SW,  0, 2, 2);          // MemWrite for 3 cycles
        do_instr(c_BEQ, 0, 0, 1);          // branch taken
        do_instr(c_BEQ, 0, 0, 0);          // branch not taken
        do_instr(7'b1111111, 0, 0, 2);     // illegal opcode
        do_instr(c_IT,  0, 0, 2);          // build-dependent I-type path
        do_instr(c_RT,  2, 0, 2);          // fetch stall
        do_instr(c_LW,  1, 3, 2);          // fetch and read stalls

        // Asynchronous reset while a store waits in MEMWRITE.
        op = c_SW;
        cycle(0, 1'b1, 1'b0);
        cycle(1, 1'b1, 1'b0);
        cycle(2, 1'b1, 1'b0);
        mem_ready = 1'b0;
        #1;
        dchk("memwrite_state_pre", 32'(state), 32'd5);
        dchk("memwrite_strobe_pre", 32'(MemWrite), 32'd1);
        rst = 1'b1;
        #1;
        dchk("arst_state", 32'(state), 32'd0);
        dchk("arst_memwrite", 32'(MemWrite), 32'd0);
        dchk("arst_vec", 32'(act), 32'(model(0, op, 1'b0, zero)));
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomised instruction stream
        for (int n = 0; n < 300; n++) begin
            do_instr(rand_op(), rand_stall(), rand_stall(), 2);
        end

        // Let the monitor drain, then confirm that nothing was left unchecked.
        @(negedge clk); #1;
        dchk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 PCWrite  out  1  PC register load enable.
REQ-008 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite  out  1  memory write strobe.
REQ-010 IRWrite  out  1  instruction register / OldPC load enable.
REQ-011 RegWrite  out  1  register file write enable.
REQ-012 ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-014 ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-015 ALUOp  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-016 ImmSrc  out  2  immediate format select.
REQ-017 illegal_op  out  1  unsupported opcode detected in DECODE.
REQ-018 state  out  4  current state encoding (debug).

Function
REQ-019 Moore FSM; outputs decode from state only, except PCWrite and IRWrite (may use zero and mem_ready) and ImmSrc (uses op).
REQ-020 State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, BEQ 9.
REQ-021 Encodings 10-15 go to FETCH on the next edge, with all outputs 0 while in them.
REQ-022 Transitions:
- FETCH to DECODE when mem_ready=1; otherwise hold.
- DECODE: op 0000011 or 0100011 to MEMADR; 0110011 to EXECUTER; 1100011 to BEQ; anything else to FETCH.
- MEMADR: to MEMREAD if op=0000011, else to MEMWRITE.
- MEMREAD to MEMWB when mem_ready=1; otherwise hold.
- MEMWRITE to FETCH when mem_ready=1; otherwise hold.
- MEMWB, ALUWB and BEQ to FETCH.
- EXECUTER and EXECUTEI to ALUWB.
REQ-023 Any output not listed for a state SHALL be 0. State outputs:
- FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle until mem_ready.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero.
REQ-024 ImmSrc is combinational from op in every state: 0000011 gives 00, 0100011 gives 01, 1100011 gives 10, 0010011 gives 00, all others give 00.
REQ-025 illegal_op=1 only in DECODE with an unsupported op (single-cycle pulse).
REQ-026 Latency with mem_ready held 1: lw 5 cycles, sw 4, R-type 4, beq 3, illegal 2; each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
REQ-027 PCWrite and IRWrite are never 1 in the same cycle outside FETCH.

Reset
REQ-028 rst=1 forces state=FETCH immediately, independent of clk, including mid-instruction; a pending MemWrite or RegWrite is dropped.
REQ-029 While rst=1, outputs equal FETCH outputs with PCWrite=0 and IRWrite=0.
REQ-030 The first fetch occurs on the first rising edge after rst falls.

Configuration
REQ-031 Macro MULTICYCLE_CONTROLLER_ITYPE_EN.
- Defined: DECODE with op=0010011 goes to EXECUTEI. EXECUTEI drives ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB (4-cycle latency).
- Undefined: op=0010011 is illegal per REQ-022 and REQ-025, and EXECUTEI is unreachable (treated as REQ-021).

Verification
REQ-032 Reset, then lw (op=0000011) with mem_ready=1: states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-033 sw (0100011) with mem_ready low for 2 cycles in MEMWRITE: MemWrite=1 for 3 cycles; FETCH entered after the cycle where mem_ready=1.
REQ-034 beq (1100011): zero=1 gives PCWrite=1 in BEQ with ALUOp=01; zero=0 gives PCWrite=0; 3 cycles total each.
REQ-035 op=1111111: illegal_op=1 for 1 cycle in DECODE, then FETCH; no RegWrite or MemWrite asserted.
REQ-036 rst asserted asynchronously in MEMWRITE: state=0 and MemWrite=0 before the next clk edge.
REQ-037 op=0010011, both builds: macro defined gives 0,1,8,7,0 with illegal_op=0; macro undefined gives 0,1,0 with illegal_op=1.
